sign_narrow_unit: RTL and testbench
===================================

Name: sign_narrow_unit

Overview:
- Inverse of the datapath sign extender: takes an IN_W-bit two's-complement value and narrows it to an OUT_W-bit signed immediate field.
- Two narrowing modes: wrap (truncate) and saturate. Every narrowing that does not fit is flagged and counted.
- Sits between the ALU result path and the immediate/encoder stage. Buffered behind a valid/ready handshake with a 2-entry output queue.

Parameters:
- IN_W, 8, input width in bits.
- OUT_W, 3, output field width in bits. Must satisfy 2 <= OUT_W < IN_W.
- CNT_W, 8, width of the overflow event counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  unit can accept a word this cycle.
- in_data  in  IN_W  signed input value.
- in_sat  in  1  mode for this word: 0 = wrap/truncate, 1 = saturate. Sampled with in_data.
- out_valid  out  1  output queue non-empty.
- out_ready  in  1  consumer takes the head word this cycle.
- out_data  out  OUT_W  narrowed signed value (head of queue).
- out_ovf  out  1  head word did not fit in OUT_W bits.
- clr_count  in  1  synchronous clear of ovf_count.
- ovf_count  out  CNT_W  number of accepted words with overflow, saturating.

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Fit test: the word fits iff in_data[IN_W-1:OUT_W-1] are all equal (all-0 or all-1).
- Narrowing result:
  - Fits: out = in_data[OUT_W-1:0], ovf = 0.
  - Does not fit, in_sat = 0: out = in_data[OUT_W-1:0] (wrapped), ovf = 1.
  - Does not fit, in_sat = 1: out = max positive (0 followed by OUT_W-1 ones, i.e. 3'b011) if in_data[IN_W-1] = 0, else min negative (1 followed by zeros, i.e. 3'b100); ovf = 1.
- The narrowing computation is combinational on the input. Its result and ovf bit are written into the queue on input transfer.
- Queue:
  - 2 entries of {ovf, data}; occupancy count 0..2.
  - in_ready = (count != 2). It is registered-state derived only and must not depend on out_ready combinationally.
  - out_valid = (count != 0). out_data and out_ovf come from the head entry. They are held stable while out_valid & !out_ready.
- Latency: a word accepted in cycle N is visible on out_valid/out_data in cycle N+1 when the queue was empty. Throughput is 1 word per cycle when out_ready is held high.
- Simultaneous push and pop:
  - count = 1: count stays 1, head becomes the new word.
  - count = 2: no push possible because in_ready = 0.
- Pop on empty is impossible because out_valid = 0.
- Ordering is strictly FIFO.
- ovf_count:
  - Increments by 1 on each input transfer whose ovf = 1.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - If clr_count is high in a cycle that also increments, the clear wins and the result is 0.
- Reset (any cycle, including mid-stream): count = 0, out_valid = 0, in_ready = 1, out_data = 0, out_ovf = 0, ovf_count = 0. Queued words are discarded. A word presented during the reset cycle is not accepted.
- X-safety: out_data and out_ovf must be 0 whenever out_valid = 0 after reset. Storage slots are reset to 0.

Decomposition:
- Shared package holds:
  - default widths (IN_W, OUT_W, CNT_W);
  - mode encodings NARROW_WRAP = 1'b0 and NARROW_SAT = 1'b1;
  - the helper constants SAT_MAX/SAT_MIN for OUT_W.
- One natural sub-module: narrow_fifo2, a generic 2-entry synchronous valid/ready queue of width OUT_W+1. The fit/saturate logic and the counter stay in the top level.

Test Plan:
- Fitting values, saturate mode, out_ready = 1: in 8'h03, 8'hFC, 8'h00, 8'hFF -> out 3'b011, 3'b100, 3'b000, 3'b111; ovf = 0 for all; 1-cycle latency; ovf_count = 0.
- Overflow, wrap mode: in 8'h05 -> out 3'b101, ovf = 1. In 8'h80 -> out 3'b000, ovf = 1. ovf_count = 2.
- Overflow, saturate mode: in 8'h7F -> 3'b011. In 8'h04 -> 3'b011. In 8'h80 -> 3'b100. In 8'hFB -> 3'b100. All have ovf = 1.
- Backpressure:
  - Hold out_ready = 0 and push 3 words -> in_ready drops after 2 accepts; the 3rd word is stalled.
  - Head stays stable while stalled.
  - Then out_ready = 1 -> the words drain in order, one per cycle; the 3rd word is accepted as soon as count < 2.
- Counter edges:
  - Preload to 8'hFE via overflow words, then push 2 more overflow words -> 8'hFF, and it holds at 8'hFF.
  - Assert clr_count together with an overflow push -> ovf_count = 0.
- Reset mid-stream: queue holds 2 words, assert rst for 1 cycle with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, ovf_count = 0, out_data = 0; the word presented during reset is not seen at the output.

Source files
------------

// File: rtl/sign_narrow_unit_pkg.sv
// Shared widths, narrowing-mode encodings and saturation bounds for the
// sign narrowing unit.
package sign_narrow_unit_pkg;

  localparam int DEF_IN_W  = 8;
  localparam int DEF_OUT_W = 3;
  localparam int DEF_CNT_W = 8;

  localparam logic NARROW_WRAP = 1'b0;
  localparam logic NARROW_SAT  = 1'b1;

  localparam logic [DEF_OUT_W-1:0] SAT_MAX = {1'b0, {(DEF_OUT_W-1){1'b1}}};
  localparam logic [DEF_OUT_W-1:0] SAT_MIN = {1'b1, {(DEF_OUT_W-1){1'b0}}};

endpackage

// File: rtl/sign_narrow_unit_fifo2.sv
// Generic 2-entry synchronous valid/ready queue. Slot 0 is always the head;
// empty slots are kept at zero so the head reads 0 whenever the queue is empty.
module narrow_fifo2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;
  logic [1:0]   wr_idx;
  logic         push;
  logic         pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = slot0_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Pop shifts slot 1 forward first; the push then lands in the first free slot.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    wr_idx  = count_q;
    if (pop) begin
      slot0_d = slot1_q;
      slot1_d = '0;
      count_d = count_q - 2'd1;
      wr_idx  = count_q - 2'd1;
    end
    if (push) begin
      if (wr_idx == 2'd0) begin
        slot0_d = in_data;
      end else begin
        slot1_d = in_data;
      end
      count_d = count_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sign_narrow_unit.sv
// Narrows a signed IN_W-bit value to an OUT_W-bit field by wrapping or
// saturating, queues {ovf, data} in a 2-entry buffer and counts overflows.
module sign_narrow_unit
  import sign_narrow_unit_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  input  logic             clr_count,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic [IN_W-OUT_W:0] top_bits;
  logic                fits;
  logic [OUT_W-1:0]    narrow_data;
  logic                narrow_ovf;
  logic                push;
  logic [CNT_W-1:0]    ovf_count_q, ovf_count_d;

  // The value fits when the discarded bits plus the new sign bit all agree.
  assign top_bits = in_data[IN_W-1:OUT_W-1];
  assign fits     = (&top_bits) | ~(|top_bits);
  assign push     = in_valid & in_ready;

  always_comb begin
    narrow_data = in_data[OUT_W-1:0];
    narrow_ovf  = ~fits;
    if (!fits) begin
      case (in_sat)
        NARROW_WRAP: narrow_data = in_data[OUT_W-1:0];
        NARROW_SAT:  narrow_data = in_data[IN_W-1] ? OUT_MIN : OUT_MAX;
        default:     narrow_data = in_data[OUT_W-1:0];
      endcase
    end
  end

  // Clear has priority over an increment arriving in the same cycle.
  always_comb begin
    ovf_count_d = ovf_count_q;
    if (clr_count) begin
      ovf_count_d = '0;
    end else if (push && narrow_ovf && (ovf_count_q != '1)) begin
      ovf_count_d = ovf_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count_q <= '0;
    end else begin
      ovf_count_q <= ovf_count_d;
    end
  end

  assign ovf_count = ovf_count_q;

  narrow_fifo2 #(
    .W(OUT_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({narrow_ovf, narrow_data}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({out_ovf, out_data})
  );

endmodule

// File: tb/tb_sign_narrow_unit.sv
// Scoreboard bench for sign_narrow_unit: an arithmetic reference model predicts
// each queued word and the overflow counter; a negedge monitor compares.
module tb_sign_narrow_unit;

  localparam int IN_W  = 8;
  localparam int OUT_W = 3;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_sat;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf;
  logic             clr_count;
  logic [CNT_W-1:0] ovf_count;

  typedef struct {
    string name;
    int    sel;
    int    exp_v;
    int    act_v;
  } dir_t;

  dir_t           dir_q[$];
  logic [OUT_W:0] exp_q[$];
  int             exp_cnt;
  int             errors;
  int             checks;
  bit             started;

  sign_narrow_unit #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sat   (in_sat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .clr_count(clr_count),
    .ovf_count(ovf_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference narrowing done on the integer value: range test, clamp, modulo.
  function automatic logic [OUT_W:0] model_narrow(input logic [IN_W-1:0] din, input logic sat);
    int   v;
    int   hi;
    int   lo;
    int   r;
    logic ovf;
    v   = $signed(din);
    hi  = (1 << (OUT_W - 1)) - 1;
    lo  = -(1 << (OUT_W - 1));
    ovf = (v > hi) || (v < lo);
    if (!ovf)     r = v;
    else if (sat) r = (v > hi) ? hi : lo;
    else          r = v;
    r = ((r % (1 << OUT_W)) + (1 << OUT_W)) % (1 << OUT_W);
    return {ovf, r[OUT_W-1:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic expectDirect(input string name, input int sel, input int expv, input int actv);
    dir_t d;
    d.name  = name;
    d.sel   = sel;
    d.exp_v = expv;
    d.act_v = actv;
    dir_q.push_back(d);
  endtask

  // Monitor: compare the cycle's visible state, then advance the model by the edge to come.
  always @(negedge clk) begin
    dir_t           d;
    logic [31:0]    act;
    logic [OUT_W:0] pred;
    logic           acc;
    logic           pop;
    if (started) begin
      while (dir_q.size() != 0) begin
        d = dir_q.pop_front();
        case (d.sel)
          0:       act = 32'(ovf_count);
          1:       act = 32'(out_valid);
          2:       act = 32'(in_ready);
          3:       act = 32'(out_data);
          4:       act = 32'(exp_q.size());
          6:       act = 32'(out_ovf);
          default: act = d.act_v;
        endcase
        checkOutput(d.name, act, d.exp_v);
      end
      checkOutput("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
      checkOutput("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      checkOutput("ovf_count", 32'(ovf_count), exp_cnt);
      if (exp_q.size() != 0)
        checkOutput("head", 32'({out_ovf, out_data}), 32'(exp_q[0]));
      else
        checkOutput("idle_zero", 32'({out_ovf, out_data}), 32'd0);
    end
    if (rst) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      acc  = in_valid && (exp_q.size() < 2);
      pop  = (exp_q.size() != 0) && out_ready;
      pred = model_narrow(in_data, in_sat);
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(pred);
      if (clr_count) exp_cnt = 0;
      else if (acc && pred[OUT_W] && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
    end
  end

  task automatic applyStimulus(input logic r, input logic v, input logic [IN_W-1:0] d,
                               input logic s, input logic ordy, input logic clr,
                               output logic acc);
    rst       = r;
    in_valid  = v;
    in_data   = d;
    in_sat    = s;
    out_ready = ordy;
    clr_count = clr;
    @(negedge clk);
    acc = v && in_ready && !r;
    @(posedge clk);
    #1;
  endtask

  logic [IN_W-1:0]  tbl_data[10];
  logic             tbl_sat[10];
  logic [OUT_W-1:0] tbl_out[10];
  logic             acc;

  initial begin
    errors  = 0;
    checks  = 0;
    exp_cnt = 0;
    started = 1'b0;
    tbl_data = '{8'h03, 8'hFC, 8'h00, 8'hFF, 8'h05, 8'h80, 8'h7F, 8'h04, 8'h80, 8'hFB};
    tbl_sat  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl_out  = '{3'b011, 3'b100, 3'b000, 3'b111, 3'b101, 3'b000, 3'b011, 3'b011, 3'b100, 3'b100};

    applyStimulus(1, 0, 8'h00, 0, 0, 0, acc);
    applyStimulus(1, 0, 8'h00, 0, 0, 0, acc);
    started = 1'b1;
    expectDirect("reset_valid", 1, 0, 0);
    expectDirect("reset_ready", 2, 1, 0);
    expectDirect("reset_count", 0, 0, 0);

    // Directed words with out_ready high: each new word is the head one cycle later.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, tbl_data[i], tbl_sat[i], 1, 0, acc);
      expectDirect("tbl_data", 3, int'(tbl_out[i]), 0);
      expectDirect("tbl_ovf", 6, (i >= 4) ? 1 : 0, 0);
      if (i == 3) expectDirect("cnt_fit", 0, 0, 0);
      if (i == 5) expectDirect("cnt_wrap", 0, 2, 0);
    end
    applyStimulus(0, 0, 8'h00, 0, 1, 0, acc);

    // Backpressure: two accepts, third stalls until a slot frees.
    applyStimulus(0, 1, 8'h01, 0, 0, 0, acc);
    expectDirect("bp_acc_a", 5, 1, int'(acc));
    applyStimulus(0, 1, 8'h02, 0, 0, 0, acc);
    expectDirect("bp_acc_b", 5, 1, int'(acc));
    applyStimulus(0, 1, 8'h03, 0, 0, 0, acc);
    expectDirect("bp_acc_c", 5, 0, int'(acc));
    expectDirect("bp_ready_low", 2, 0, 0);
    applyStimulus(0, 1, 8'h03, 0, 0, 0, acc);
    expectDirect("bp_head_hold", 3, 1, 0);
    acc = 1'b0;
    for (int i = 0; i < 6 && !acc; i++) applyStimulus(0, 1, 8'h03, 0, 1, 0, acc);
    expectDirect("bp_third_accept", 5, 1, int'(acc));
    repeat (3) applyStimulus(0, 0, 8'h00, 0, 1, 0, acc);

    // Counter saturation and clear priority.
    applyStimulus(0, 0, 8'h00, 0, 1, 1, acc);
    repeat (254) applyStimulus(0, 1, 8'h40, 0, 1, 0, acc);
    expectDirect("cnt_fe", 0, 254, 0);
    repeat (2) applyStimulus(0, 1, 8'h40, 0, 1, 0, acc);
    expectDirect("cnt_ff", 0, 255, 0);
    repeat (2) applyStimulus(0, 1, 8'hC0, 1, 1, 0, acc);
    expectDirect("cnt_hold", 0, 255, 0);
    applyStimulus(0, 1, 8'h40, 0, 1, 1, acc);
    expectDirect("cnt_clr_wins", 0, 0, 0);

    // Reset mid-stream with a word presented during the reset cycle.
    applyStimulus(0, 1, 8'h11, 0, 0, 0, acc);
    applyStimulus(0, 1, 8'h22, 0, 0, 0, acc);
    applyStimulus(1, 1, 8'h7F, 1, 0, 0, acc);
    expectDirect("mid_reset_valid", 1, 0, 0);
    expectDirect("mid_reset_ready", 2, 1, 0);
    expectDirect("mid_reset_count", 0, 0, 0);
    expectDirect("mid_reset_data", 3, 0, 0);
    repeat (2) applyStimulus(0, 0, 8'h00, 0, 1, 0, acc);

    // Randomized traffic, including occasional clears and resets.
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(63) == 0), ($urandom_range(3) != 0), 8'($urandom),
                    1'($urandom), ($urandom_range(2) != 0), ($urandom_range(31) == 0), acc);
    end

    repeat (4) applyStimulus(0, 0, 8'h00, 0, 1, 0, acc);
    expectDirect("drained", 4, 0, 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
